// File: rtl/user_event_queue_if.sv
// Event stream between the input stage and the game logic: show-ahead head
// event, not-empty flag, pop request and the dropped-event pulse.
interface user_event_queue_if;
    logic [2:0] user_event_o;
    logic       user_event_ready_o;
    logic       user_event_rd_req_i;
    logic       overflow_o;

    modport master (
        output user_event_o,
        output user_event_ready_o,
        output overflow_o,
        input  user_event_rd_req_i
    );

    modport slave (
        input  user_event_o,
        input  user_event_ready_o,
        input  overflow_o,
        output user_event_rd_req_i
    );
endinterface

// File: rtl/user_event_queue.sv
// Player button front end: synchronise, debounce, press edge detection,
// autorepeat on left/right/down, one pending flag per source, a fixed-priority
// arbiter and a small show-ahead FIFO feeding the game logic.
module user_event_queue #(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int AUTOREPEAT_DELAY  = 12500000,
    parameter int AUTOREPEAT_PERIOD = 5000000,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_left_i,
    input  logic btn_right_i,
    input  logic btn_down_i,
    input  logic btn_rotate_i,
    input  logic btn_new_game_i,
    user_event_queue_if.master evt
);
    localparam logic [2:0] EV_LEFT     = 3'd1;
    localparam logic [2:0] EV_RIGHT    = 3'd2;
    localparam logic [2:0] EV_DOWN     = 3'd3;
    localparam logic [2:0] EV_ROTATE   = 3'd4;
    localparam logic [2:0] EV_NEW_GAME = 3'd5;

    localparam int NSRC         = 5;
    localparam int NREP         = 3;
    localparam int SRC_LEFT     = 0;
    localparam int SRC_RIGHT    = 1;
    localparam int SRC_DOWN     = 2;
    localparam int SRC_ROTATE   = 3;
    localparam int SRC_NEW_GAME = 4;

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (AUTOREPEAT_DELAY > AUTOREPEAT_PERIOD) ? AUTOREPEAT_DELAY : AUTOREPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [NSRC-1:0] btn_raw;
    logic [NSRC-1:0] sync1_q, sync1_d;
    logic [NSRC-1:0] sync2_q, sync2_d;
    logic [NSRC-1:0] stable_q, stable_d;
    logic [NSRC-1:0] stable_prev_q, stable_prev_d;
    logic [DB_W-1:0] db_cnt_q [NSRC];
    logic [DB_W-1:0] db_cnt_d [NSRC];
    logic [RP_W-1:0] rep_cnt_q [NREP];
    logic [RP_W-1:0] rep_cnt_d [NREP];
    logic [NREP-1:0] rep_phase_q, rep_phase_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic            overflow_q, overflow_d;
    logic [2:0]      mem_q [FIFO_DEPTH];
    logic [2:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [NSRC-1:0] press;
    logic [NREP-1:0] rep_req;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] grant;
    logic [NSRC-1:0] clear;
    logic [2:0]      push_code;
    logic            pop;
    logic            push;
    logic            can_push;

    assign btn_raw = {btn_new_game_i, btn_rotate_i, btn_down_i, btn_right_i, btn_left_i};

    // Two-stage synchroniser for the asynchronous button inputs.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    // Debounce: stable level flips only after the synced level has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        for (int i = 0; i < NSRC; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
        press = stable_q & ~stable_prev_q;
    end

    // Autorepeat for the movement buttons: first repeat after the initial delay, then one per period until release.
    always_comb begin
        rep_phase_d = rep_phase_q;
        rep_req     = '0;
        for (int i = 0; i < NREP; i++) begin
            rep_cnt_d[i] = '0;
            if (!stable_q[i]) begin
                rep_phase_d[i] = 1'b0;
            end else if (rep_cnt_q[i] == (rep_phase_q[i] ? RP_W'(AUTOREPEAT_PERIOD) : RP_W'(AUTOREPEAT_DELAY))) begin
                rep_req[i]     = 1'b1;
                rep_cnt_d[i]   = RP_W'(1);
                rep_phase_d[i] = 1'b1;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + RP_W'(1);
            end
        end
        req = press | {{(NSRC - NREP){1'b0}}, rep_req};
    end

    // Pending flags, fixed-priority arbitration and the FIFO push/pop bookkeeping.
    always_comb begin
        grant     = '0;
        push_code = 3'd0;
        if (pending_q[SRC_NEW_GAME]) begin
            grant[SRC_NEW_GAME] = 1'b1;
            push_code           = EV_NEW_GAME;
        end else if (pending_q[SRC_ROTATE]) begin
            grant[SRC_ROTATE] = 1'b1;
            push_code         = EV_ROTATE;
        end else if (pending_q[SRC_LEFT]) begin
            grant[SRC_LEFT] = 1'b1;
            push_code       = EV_LEFT;
        end else if (pending_q[SRC_RIGHT]) begin
            grant[SRC_RIGHT] = 1'b1;
            push_code        = EV_RIGHT;
        end else if (pending_q[SRC_DOWN]) begin
            grant[SRC_DOWN] = 1'b1;
            push_code       = EV_DOWN;
        end

        pop      = evt.user_event_rd_req_i && (count_q != '0);
        can_push = (count_q != CNT_W'(FIFO_DEPTH)) || pop;
        push     = can_push && (pending_q != '0);
        clear    = push ? grant : '0;

        pending_d  = (pending_q & ~clear) | req;
        overflow_d = |(req & pending_q & ~clear);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_code;
        end
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State register for every stage, cleared asynchronously by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            db_cnt_q      <= '{default: '0};
            rep_cnt_q     <= '{default: '0};
            rep_phase_q   <= '0;
            pending_q     <= '0;
            overflow_q    <= 1'b0;
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            db_cnt_q      <= db_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            rep_phase_q   <= rep_phase_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    assign evt.user_event_o       = (count_q != '0) ? mem_q[rd_ptr_q] : 3'd0;
    assign evt.user_event_ready_o = (count_q != '0);
    assign evt.overflow_o         = overflow_q;

endmodule

// File: tb/tb_user_event_queue.sv
// Bench for user_event_queue: directed button scenarios followed by random
// button/pop traffic, checked against a behavioural model and a scoreboard of
// expected events.
module tb_user_event_queue;
    localparam int DB    = 4;
    localparam int DLY   = 20;
    localparam int PER   = 8;
    localparam int DEPTH = 4;

    localparam logic [2:0] EV_LEFT     = 3'd1;
    localparam logic [2:0] EV_RIGHT    = 3'd2;
    localparam logic [2:0] EV_DOWN     = 3'd3;
    localparam logic [2:0] EV_ROTATE   = 3'd4;
    localparam logic [2:0] EV_NEW_GAME = 3'd5;

    localparam logic [2:0] CODE_OF [5] = '{EV_LEFT, EV_RIGHT, EV_DOWN, EV_ROTATE, EV_NEW_GAME};
    localparam int         PRIO    [5] = '{4, 3, 0, 1, 2};

    localparam logic [4:0] B_LEFT   = 5'b00001;
    localparam logic [4:0] B_RIGHT  = 5'b00010;
    localparam logic [4:0] B_DOWN   = 5'b00100;
    localparam logic [4:0] B_ROTATE = 5'b01000;
    localparam logic [4:0] B_NEW    = 5'b10000;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] btns;
    logic       rd_req;
    logic       btn_left_i, btn_right_i, btn_down_i, btn_rotate_i, btn_new_game_i;

    int checks_done   = 0;
    int checks_failed = 0;

    user_event_queue_if evt_if ();

    assign btn_left_i                 = btns[0];
    assign btn_right_i                = btns[1];
    assign btn_down_i                 = btns[2];
    assign btn_rotate_i               = btns[3];
    assign btn_new_game_i             = btns[4];
    assign evt_if.user_event_rd_req_i = rd_req;

    user_event_queue #(
        .DEBOUNCE_CYCLES   (DB),
        .AUTOREPEAT_DELAY  (DLY),
        .AUTOREPEAT_PERIOD (PER),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .btn_left_i     (btn_left_i),
        .btn_right_i    (btn_right_i),
        .btn_down_i     (btn_down_i),
        .btn_rotate_i   (btn_rotate_i),
        .btn_new_game_i (btn_new_game_i),
        .evt            (evt_if)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model state: input delay line, debounced level, hold time, pending flags, occupancy.
    bit         m_samp1 [5];
    bit         m_samp2 [5];
    bit         m_stable [5];
    bit         m_stable_last [5];
    bit         m_pend [5];
    bit         m_req [5];
    int         m_held [5];
    bit [31:0]  m_hist [5];
    int         m_hist_len [5];
    int         m_count;
    bit         m_ovf;
    int         m_grant;
    bit         m_pop;
    bit         m_ovf_next;
    logic [2:0] sb_q [$];
    logic [2:0] sb_exp;

    function automatic bit repeat_due(input int held);
        return (held == DLY) || (held > DLY && ((held - DLY) % PER) == 0);
    endfunction

    function automatic bit all_differ(input bit [31:0] hist, input int len, input bit level);
        bit [31:0] mask;
        mask = (32'd1 << DB) - 32'd1;
        if (len < DB) return 1'b0;
        return level ? ((hist & mask) == 32'd0) : ((hist & mask) == mask);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_done++;
        if (actual !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [4:0] b, input logic rd, input int cycles);
        btns   = b;
        rd_req = rd;
        repeat (cycles) @(posedge clk_i);
        #1;
    endtask

    // Reference model: advances one clock from the event rules, pushing every accepted event onto the scoreboard.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 5; i++) begin
                m_samp1[i]       = 1'b0;
                m_samp2[i]       = 1'b0;
                m_stable[i]      = 1'b0;
                m_stable_last[i] = 1'b0;
                m_pend[i]        = 1'b0;
                m_held[i]        = 0;
                m_hist[i]        = '0;
                m_hist_len[i]    = 0;
            end
            m_count = 0;
            m_ovf   = 1'b0;
            sb_q.delete();
        end else begin
            for (int i = 0; i < 5; i++) begin
                m_req[i] = m_stable[i] && !m_stable_last[i];
                if (i < 3 && m_stable[i] && repeat_due(m_held[i])) m_req[i] = 1'b1;
            end
            m_pop   = rd_req && (m_count > 0);
            m_grant = -1;
            if (m_count < DEPTH || m_pop) begin
                for (int k = 0; k < 5; k++) begin
                    if (m_grant < 0 && m_pend[PRIO[k]]) m_grant = PRIO[k];
                end
            end
            if (m_grant >= 0) begin
                m_pend[m_grant] = 1'b0;
                sb_q.push_back(CODE_OF[m_grant]);
            end
            m_ovf_next = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (m_req[i]) begin
                    if (m_pend[i]) m_ovf_next = 1'b1;
                    m_pend[i] = 1'b1;
                end
            end
            m_count = m_count + ((m_grant >= 0) ? 1 : 0) - (m_pop ? 1 : 0);
            m_ovf   = m_ovf_next;
            for (int i = 0; i < 5; i++) begin
                m_held[i]        = m_stable[i] ? m_held[i] + 1 : 0;
                m_stable_last[i] = m_stable[i];
                m_hist[i]        = {m_hist[i][30:0], m_samp2[i]};
                if (m_hist_len[i] < DB) m_hist_len[i]++;
                if (all_differ(m_hist[i], m_hist_len[i], m_stable[i])) m_stable[i] = ~m_stable[i];
                m_samp2[i] = m_samp1[i];
                m_samp1[i] = btns[i];
            end
        end
    end

    // Monitor: checks flags every cycle and pops the scoreboard whenever the consumer takes the head event.
    always @(negedge clk_i) begin
        if (rst_i) begin
            check_output("reset_ready", evt_if.user_event_ready_o, 0);
            check_output("reset_event", evt_if.user_event_o, 0);
            check_output("reset_overflow", evt_if.overflow_o, 0);
        end else begin
            check_output("ready", evt_if.user_event_ready_o, (m_count > 0) ? 1 : 0);
            check_output("overflow", evt_if.overflow_o, m_ovf);
            if (evt_if.user_event_ready_o === 1'b1 && rd_req) begin
                if (sb_q.size() == 0) begin
                    checks_done++;
                    checks_failed++;
                    $display("[TB] FAIL pop_event: got %0d, expected no event at %0t", evt_if.user_event_o, $time);
                end else begin
                    sb_exp = sb_q.pop_front();
                    check_output("pop_event", evt_if.user_event_o, sb_exp);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then random traffic, then a final drain.
    initial begin
        rst_i  = 1'b0;
        btns   = '0;
        rd_req = 1'b0;
        #1 rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        $display("[TB] rotate press, no repeats");
        apply_stimulus(B_ROTATE, 1'b0, 30);
        apply_stimulus(5'b0, 1'b0, 10);
        apply_stimulus(5'b0, 1'b1, 8);

        $display("[TB] short glitches on left");
        for (int n = 0; n < 10; n++) begin
            apply_stimulus(B_LEFT, 1'b0, 3);
            apply_stimulus(5'b0, 1'b0, 5);
        end
        apply_stimulus(5'b0, 1'b0, 10);

        $display("[TB] right held, FIFO fills and overflows");
        apply_stimulus(B_RIGHT, 1'b0, 60);
        apply_stimulus(5'b0, 1'b0, 15);
        apply_stimulus(5'b0, 1'b1, 12);

        $display("[TB] down and new_game together");
        apply_stimulus(B_DOWN | B_NEW, 1'b0, 12);
        apply_stimulus(5'b0, 1'b0, 10);
        apply_stimulus(5'b0, 1'b1, 8);

        $display("[TB] push and pop on a full FIFO");
        apply_stimulus(B_RIGHT, 1'b0, 42);
        apply_stimulus(5'b0, 1'b0, 12);
        apply_stimulus(B_ROTATE, 1'b0, 7);
        apply_stimulus(B_ROTATE, 1'b1, 1);
        apply_stimulus(B_ROTATE, 1'b0, 10);
        apply_stimulus(5'b0, 1'b1, 12);

        $display("[TB] reset while queued and left held");
        apply_stimulus(B_LEFT | B_ROTATE, 1'b0, 12);
        btns = B_LEFT;
        #2 rst_i = 1'b1;
        #1;
        check_output("async_reset_ready", evt_if.user_event_ready_o, 0);
        check_output("async_reset_event", evt_if.user_event_o, 0);
        check_output("async_reset_overflow", evt_if.overflow_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        apply_stimulus(B_LEFT, 1'b0, 40);
        apply_stimulus(5'b0, 1'b1, 15);

        $display("[TB] random traffic");
        for (int s = 0; s < 80; s++) begin
            apply_stimulus(5'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0), $urandom_range(1, 30));
        end
        apply_stimulus(5'b0, 1'b1, 60);
        check_output("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end
endmodule

// File: doc/user_event_queue.md
Name: user_event_queue

Overview:
- Upstream input stage for the game logic. Converts raw player buttons into the 3-bit user event stream that main_game_logic consumes.
- Signal path per button: synchronise, debounce, detect press edges, and generate autorepeat for the movement buttons.
- Events are arbitrated into a show-ahead FIFO and popped by the consumer's read request.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive cycles a synced input must differ from its stable value before the stable value flips.
- AUTOREPEAT_DELAY, 12500000: cycles of hold after a press before the first repeat (left/right/down only).
- AUTOREPEAT_PERIOD, 5000000: cycles between subsequent repeats.
- FIFO_DEPTH, 4: event FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- btn_left_i  in  1  raw asynchronous button, active-high
- btn_right_i  in  1  raw asynchronous button, active-high
- btn_down_i  in  1  raw asynchronous button, active-high
- btn_rotate_i  in  1  raw asynchronous button, active-high
- btn_new_game_i  in  1  raw asynchronous button, active-high
- user_event_o  out  3  FIFO head event code (`EV_LEFT, `EV_RIGHT, `EV_DOWN, `EV_ROTATE, `EV_NEW_GAME from defs.vh)
- user_event_ready_o  out  1  FIFO not empty
- user_event_rd_req_i  in  1  pop request from the consumer
- overflow_o  out  1  single-cycle pulse: an event was dropped

Behaviour:
- Reset (rst_i asynchronous, active-high; clock clk_i) clears all of the following:
  - synchronisers and debounce counters
  - stable levels (set to 0)
  - repeat counters
  - pending flags
  - FIFO pointers
- Output values during reset: user_event_o = 0, user_event_ready_o = 0, overflow_o = 0.
- A button held through reset deasserts to stable 0. It therefore produces a press event once debounced after reset.
- Synchroniser: each button passes through a 2-FF synchroniser.
- Debounce:
  - A per-button counter increments while synced != stable and clears while synced == stable.
  - When the counter reaches DEBOUNCE_CYCLES, stable flips and the counter clears.
- Press: stable transition 0->1 raises the source's event request for one cycle. Release (1->0) generates no event.
- Autorepeat (left, right, down):
  - While stable stays 1, a repeat counter runs from the press.
  - A request is raised at AUTOREPEAT_DELAY cycles, then every AUTOREPEAT_PERIOD cycles after that.
  - Release stops repeats immediately and clears the counter.
  - Rotate and new_game never repeat.
- Pending flags, one per source:
  - A request sets the flag.
  - A request on a source whose flag is already set is dropped, and overflow_o pulses in the following cycle.
- Arbiter:
  - Each cycle, if any flag is pending and the FIFO can accept, it pushes exactly one event.
  - Priority, highest first: NEW_GAME > ROTATE > LEFT > RIGHT > DOWN.
  - The pushed source's flag clears.
  - A request arriving on the same cycle its flag is cleared re-sets the flag; it is not dropped.
- FIFO:
  - Show-ahead: user_event_o is valid whenever user_event_ready_o = 1.
  - Pop occurs when user_event_rd_req_i && user_event_ready_o.
  - rd_req while empty is ignored.
  - Push is allowed when not full, or when full with a pop in the same cycle.
  - Simultaneous push and pop on an empty FIFO is not possible (no pop while empty), so the new entry becomes visible the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. A count register of width clog2(FIFO_DEPTH)+1 distinguishes full from empty.
  - While the FIFO is full, pending flags hold. No event is lost until a second request hits the same source, at which point overflow_o pulses.
- Latency: raw input rises and stays high, sampled at clock edge 0.
  - Synced level goes high at edge 2.
  - Stable level goes high at edge 2 + DEBOUNCE_CYCLES.
  - Pending flag sets at edge 3 + DEBOUNCE_CYCLES.
  - FIFO entry is written at edge 4 + DEBOUNCE_CYCLES, so user_event_ready_o goes high after that edge.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES = 4, AUTOREPEAT_DELAY = 20, AUTOREPEAT_PERIOD = 8, FIFO_DEPTH = 4.
1. Reset with all buttons low, then btn_rotate_i high for 30 cycles -> exactly one `EV_ROTATE entry; user_event_ready_o rises 8 edges after the input rise; no repeats.
2. btn_left_i pulses high for 3 cycles, 10 times, with 5-cycle gaps -> no events, ready stays 0, overflow_o stays 0.
3. btn_right_i held for 60 cycles with no pops -> 4 `EV_RIGHT entries: press plus repeats at +20, +28 and +36 cycles. The FIFO is then full, the repeat at +44 cycles stays pending, and the repeat at +52 cycles pulses overflow_o once. The pending entry is pushed on the first pop.
4. btn_down_i and btn_new_game_i rise on the same cycle -> FIFO order is `EV_NEW_GAME then `EV_DOWN, on consecutive cycles.
5. FIFO full with rd_req held high while a new rotate press arrives -> pop and push occur in the same cycle; occupancy stays 4; the head sequence is preserved; no overflow.
6. rst_i asserted mid-operation with 2 queued entries and btn_left_i held -> ready = 0 immediately. After release, one `EV_LEFT appears 8 edges later, followed by repeats.
